// File: rtl/memShare_config_pkg.sv
// memShare_config_pkg
//   Shared configuration for the memShare array request tracker:
//   - share-group geometry, shared-column map and tracker depth
//   - DRC flag count and the bit index of each DRC flag
//   - tracker head-status FSM state encoding
//   - stored entry layout (request pattern + allocation-sequence count)
package memShare_config_pkg;

  localparam int                            SHARE_GROUP_SIZE     = 5;
  localparam logic [SHARE_GROUP_SIZE-1:0]   SHARE_COL_CONFIG     = 5'b10101;
  localparam int                            ARR_RQST_TRACK_DEPTH = 4;
  localparam int                            MAX_ALLOC_SEQ_NUM    = 2;
  localparam int                            MEMSHARE_DRC_NUM     = 3;
  localparam int                            ENTRY_SEQ_W          = $clog2(MAX_ALLOC_SEQ_NUM + 1);

  // Bit positions inside drc_flag_o.
  typedef enum logic [1:0] {
    DRC_ALLOC_OVF    = 2'd0,  // shared_cnt exceeded MAX_ALLOC_SEQ_NUM on push
    DRC_ZERO_PATTERN = 2'd1,  // all-zero pattern pushed
    DRC_FULL_DROP    = 2'd2   // request presented while full, dropped
  } memShare_drc_index;

  typedef enum logic [1:0] {
    TRK_EMPTY   = 2'd0,
    TRK_PARTIAL = 2'd1,
    TRK_FULL    = 2'd2
  } tracker_state_e;

  typedef struct packed {
    logic [SHARE_GROUP_SIZE-1:0] pattern;
    logic [ENTRY_SEQ_W-1:0]      seq_num;
  } entry_t;

endpackage

// File: rtl/memshare_arr_rqst_tracker_if.sv
// memshare_arr_rqst_tracker_if
//   Request / head / status bundle of the array request tracker.
//   master : producer+consumer side (drives rqst_*, pop_i, drc_clr_i)
//   slave  : tracker side (drives rqst_ready_o, entry_*, occupancy_o, drc_flag_o)
interface memshare_arr_rqst_tracker_if #(
  parameter int SHARE_GROUP_SIZE  = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter int TRACK_DEPTH       = memShare_config_pkg::ARR_RQST_TRACK_DEPTH,
  parameter int MAX_ALLOC_SEQ_NUM = memShare_config_pkg::MAX_ALLOC_SEQ_NUM,
  parameter int DRC_NUM           = memShare_config_pkg::MEMSHARE_DRC_NUM
);
  localparam int SEQ_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);
  localparam int CNT_W = $clog2(TRACK_DEPTH + 1);

  logic                        rqst_valid_i;
  logic [SHARE_GROUP_SIZE-1:0] rqst_pattern_i;
  logic                        rqst_ready_o;
  logic                        pop_i;
  logic                        entry_valid_o;
  logic [SHARE_GROUP_SIZE-1:0] entry_pattern_o;
  logic [SEQ_W-1:0]            entry_seq_num_o;
  logic [CNT_W-1:0]            occupancy_o;
  logic [DRC_NUM-1:0]          drc_flag_o;
  logic                        drc_clr_i;

  modport master (
    output rqst_valid_i, rqst_pattern_i, pop_i, drc_clr_i,
    input  rqst_ready_o, entry_valid_o, entry_pattern_o, entry_seq_num_o, occupancy_o, drc_flag_o
  );

  modport slave (
    input  rqst_valid_i, rqst_pattern_i, pop_i, drc_clr_i,
    output rqst_ready_o, entry_valid_o, entry_pattern_o, entry_seq_num_o, occupancy_o, drc_flag_o
  );
endinterface

// File: rtl/memshare_seq_num_calc.sv
// memshare_seq_num_calc
//   Combinational allocation-sequence count for one request pattern.
//   pattern      : one bit per requestor
//   seq_num      : 0 for empty pattern, 1 for <=1 shared column, else
//                  min(shared_cnt, MAX_ALLOC_SEQ_NUM)
//   alloc_ovf    : shared_cnt > MAX_ALLOC_SEQ_NUM
//   zero_pattern : pattern is all-zero
module memshare_seq_num_calc #(
  parameter int                          SHARE_GROUP_SIZE  = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG  = memShare_config_pkg::SHARE_COL_CONFIG,
  parameter int                          MAX_ALLOC_SEQ_NUM = memShare_config_pkg::MAX_ALLOC_SEQ_NUM,
  localparam int                         SEQ_W             = $clog2(MAX_ALLOC_SEQ_NUM + 1)
) (
  input  logic [SHARE_GROUP_SIZE-1:0] pattern,
  output logic [SEQ_W-1:0]            seq_num,
  output logic                        alloc_ovf,
  output logic                        zero_pattern
);
  int shared_cnt;

  // Popcount of requestors landing on shared columns, then saturate.
  always_comb begin
    shared_cnt = 0;
    for (int i = 0; i < SHARE_GROUP_SIZE; i++) begin
      shared_cnt = shared_cnt + int'(pattern[i] & SHARE_COL_CONFIG[i]);
    end
    zero_pattern = (pattern == '0);
    alloc_ovf    = (shared_cnt > MAX_ALLOC_SEQ_NUM);
    if (zero_pattern) begin
      seq_num = '0;
    end else if (shared_cnt <= 1) begin
      seq_num = SEQ_W'(1);
    end else if (alloc_ovf) begin
      seq_num = SEQ_W'(MAX_ALLOC_SEQ_NUM);
    end else begin
      seq_num = SEQ_W'(shared_cnt);
    end
  end
endmodule

// File: rtl/memshare_arr_rqst_tracker.sv
// memshare_arr_rqst_tracker
//   FIFO of arrival request patterns with per-entry allocation-sequence
//   count, head-status FSM and sticky design-rule-check flags.
//   sys_clk : rising-edge clock
//   rst     : asynchronous active-high reset (drops all entries)
//   bus     : slave side of memshare_arr_rqst_tracker_if
//             push = rqst_valid_i & rqst_ready_o, pop = pop_i & entry_valid_o,
//             entry_* shows the registered head, zero when empty.
module memshare_arr_rqst_tracker #(
  parameter int                          SHARE_GROUP_SIZE  = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG  = memShare_config_pkg::SHARE_COL_CONFIG,
  parameter int                          TRACK_DEPTH       = memShare_config_pkg::ARR_RQST_TRACK_DEPTH,
  parameter int                          MAX_ALLOC_SEQ_NUM = memShare_config_pkg::MAX_ALLOC_SEQ_NUM,
  parameter int                          DRC_NUM           = memShare_config_pkg::MEMSHARE_DRC_NUM
) (
  input logic                             sys_clk,
  input logic                             rst,
  memshare_arr_rqst_tracker_if.slave      bus
);
  import memShare_config_pkg::*;

  localparam int PTR_W = $clog2(TRACK_DEPTH);
  localparam int CNT_W = $clog2(TRACK_DEPTH + 1);
  localparam int SEQ_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);

  entry_t             mem [TRACK_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               ready_r;
  logic               head_valid;
  entry_t             head;
  logic [DRC_NUM-1:0] drc;
  tracker_state_e     state;

  logic               push;
  logic               pop;
  logic [SEQ_W-1:0]   calc_seq;
  logic               calc_ovf;
  logic               calc_zero;
  entry_t             new_entry;
  logic [CNT_W-1:0]   count_nxt;
  logic [PTR_W-1:0]   rd_nxt;
  entry_t             head_nxt;
  logic [DRC_NUM-1:0] drc_set;
  logic [DRC_NUM-1:0] drc_nxt;

  memshare_seq_num_calc #(
    .SHARE_GROUP_SIZE  (SHARE_GROUP_SIZE),
    .SHARE_COL_CONFIG  (SHARE_COL_CONFIG),
    .MAX_ALLOC_SEQ_NUM (MAX_ALLOC_SEQ_NUM)
  ) u_seq_num_calc (
    .pattern      (bus.rqst_pattern_i),
    .seq_num      (calc_seq),
    .alloc_ovf    (calc_ovf),
    .zero_pattern (calc_zero)
  );

  // Next-state computation for pointers, occupancy, head register and DRC flags.
  always_comb begin
    push      = bus.rqst_valid_i & ready_r;
    pop       = bus.pop_i & head_valid;
    new_entry = '{pattern: bus.rqst_pattern_i, seq_num: calc_seq};
    rd_nxt    = rd_ptr + PTR_W'(pop);
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
    // When the pushed entry becomes the only remaining one it is not yet
    // in the array, so forward it straight into the head register.
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (push && (count == {{(CNT_W-1){1'b0}}, pop})) begin
      head_nxt = new_entry;
    end else begin
      head_nxt = mem[rd_nxt];
    end
    drc_set                   = '0;
    drc_set[DRC_ALLOC_OVF]    = push & calc_ovf;
    drc_set[DRC_ZERO_PATTERN] = push & calc_zero;
    drc_set[DRC_FULL_DROP]    = bus.rqst_valid_i & ~ready_r;
    // A set event in the same cycle as a clear keeps the flag set.
    if (bus.drc_clr_i) begin
      drc_nxt = drc_set;
    end else begin
      drc_nxt = drc | drc_set;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers, occupancy, ready, head and DRC registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_r    <= 1'b1;
      head_valid <= 1'b0;
      head       <= '0;
      drc        <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push);
      rd_ptr     <= rd_nxt;
      count      <= count_nxt;
      ready_r    <= (count_nxt < CNT_W'(TRACK_DEPTH));
      head_valid <= (count_nxt != '0);
      head       <= head_nxt;
      drc        <= drc_nxt;
    end
  end

  // Head-status FSM (EMPTY / PARTIAL / FULL).
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= TRK_EMPTY;
    end else begin
      case (state)
        TRK_EMPTY: begin
          if (push) state <= TRK_PARTIAL;
          else      state <= TRK_EMPTY;
        end
        TRK_PARTIAL: begin
          if (push && !pop && (count_nxt == CNT_W'(TRACK_DEPTH))) state <= TRK_FULL;
          else if (pop && !push && (count_nxt == '0))              state <= TRK_EMPTY;
          else                                                     state <= TRK_PARTIAL;
        end
        TRK_FULL: begin
          if (pop) state <= TRK_PARTIAL;
          else     state <= TRK_FULL;
        end
        default: state <= TRK_EMPTY;
      endcase
    end
  end

  assign bus.rqst_ready_o    = ready_r;
  assign bus.entry_valid_o   = head_valid;
  assign bus.entry_pattern_o = head.pattern;
  assign bus.entry_seq_num_o = head.seq_num;
  assign bus.occupancy_o     = count;
  assign bus.drc_flag_o      = drc;
endmodule

// File: tb/tb_memshare_arr_rqst_tracker.sv
// tb_memshare_arr_rqst_tracker
//   Directed-vector bench for memshare_arr_rqst_tracker. Inputs change on the
//   falling edge; outputs are sampled on the following falling edge.
module tb_memshare_arr_rqst_tracker;
  logic sys_clk;
  logic rst;
  int   checks;
  int   errors;

  memshare_arr_rqst_tracker_if bus ();

  memshare_arr_rqst_tracker dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic cycle();
    @(negedge sys_clk);
  endtask

  task automatic idle();
    bus.rqst_valid_i   = 1'b0;
    bus.rqst_pattern_i = 5'b00000;
    bus.pop_i          = 1'b0;
    bus.drc_clr_i      = 1'b0;
  endtask

  task automatic push(input logic [4:0] p);
    bus.rqst_valid_i = 1'b1; bus.rqst_pattern_i = p; cycle(); idle();
  endtask

  task automatic pop_one();
    bus.pop_i = 1'b1; cycle(); idle();
  endtask

  task automatic clear_drc();
    bus.drc_clr_i = 1'b1; cycle(); idle();
  endtask

  task automatic check_head(input string name, input logic v, input logic [4:0] p, input logic [1:0] s, input logic [2:0] occ);
    checks++;
    if (bus.entry_valid_o !== v || bus.entry_pattern_o !== p || bus.entry_seq_num_o !== s || bus.occupancy_o !== occ) begin
      errors++;
      $display("FAIL %s actual v=%b pat=%b seq=%0d occ=%0d required v=%b pat=%b seq=%0d occ=%0d",
               name, bus.entry_valid_o, bus.entry_pattern_o, bus.entry_seq_num_o, bus.occupancy_o, v, p, s, occ);
    end
  endtask

  task automatic check_status(input string name, input logic rdy, input logic [2:0] drc);
    checks++;
    if (bus.rqst_ready_o !== rdy || bus.drc_flag_o !== drc) begin
      errors++;
      $display("FAIL %s actual ready=%b drc=%b required ready=%b drc=%b", name, bus.rqst_ready_o, bus.drc_flag_o, rdy, drc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    cycle(); cycle();
    check_head("reset_head", 1'b0, 5'b00000, 2'd0, 3'd0);
    check_status("reset_status", 1'b1, 3'b000);
    rst = 1'b0;
    cycle();
    check_head("after_reset_head", 1'b0, 5'b00000, 2'd0, 3'd0);
  endtask

  task automatic test_single_push();
    push(5'b00100);
    check_head("single_push_head", 1'b1, 5'b00100, 2'd1, 3'd1);
    check_status("single_push_status", 1'b1, 3'b000);
    pop_one();
    check_head("single_pop_empty", 1'b0, 5'b00000, 2'd0, 3'd0);
    pop_one();
    check_head("pop_while_empty", 1'b0, 5'b00000, 2'd0, 3'd0);
    check_status("pop_while_empty_status", 1'b1, 3'b000);
  endtask

  task automatic test_seq_drc();
    push(5'b10101);
    check_head("ovf_push_head", 1'b1, 5'b10101, 2'd2, 3'd1);
    check_status("ovf_drc1", 1'b1, 3'b001);
    push(5'b00000);
    check_head("zero_push_keeps_head", 1'b1, 5'b10101, 2'd2, 3'd2);
    check_status("zero_drc2", 1'b1, 3'b011);
    pop_one();
    check_head("zero_entry_head", 1'b1, 5'b00000, 2'd0, 3'd1);
    pop_one();
    clear_drc();
    check_status("drc_cleared", 1'b1, 3'b000);
    push(5'b11000);
    check_head("one_shared_seq1", 1'b1, 5'b11000, 2'd1, 3'd1);
    pop_one();
    push(5'b10100);
    check_head("two_shared_seq2", 1'b1, 5'b10100, 2'd2, 3'd1);
    check_status("two_shared_no_drc", 1'b1, 3'b000);
    pop_one();
  endtask

  task automatic test_full_drop();
    logic [4:0] pats [4];
    logic [1:0] seqs [4];
    pats = '{5'b00001, 5'b00110, 5'b10001, 5'b01000};
    seqs = '{2'd1, 2'd1, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) push(pats[i]);
    check_status("three_still_ready", 1'b1, 3'b000);
    push(pats[3]);
    check_head("full_head", 1'b1, pats[0], seqs[0], 3'd4);
    check_status("full_not_ready", 1'b0, 3'b000);
    push(5'b11111);
    check_head("drop_keeps_occ", 1'b1, pats[0], seqs[0], 3'd4);
    check_status("drop_drc3", 1'b0, 3'b100);
    for (int i = 1; i < 4; i++) begin
      pop_one();
      check_head("drain_order", 1'b1, pats[i], seqs[i], 3'(4 - i));
    end
    pop_one();
    check_head("drained_empty", 1'b0, 5'b00000, 2'd0, 3'd0);
    check_status("drained_ready", 1'b1, 3'b100);
    clear_drc();
  endtask

  task automatic test_back_to_back();
    logic [1:0] seqs [10];
    seqs = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1};
    push(5'b00001);
    push(5'b00010);
    bus.rqst_valid_i = 1'b1; bus.rqst_pattern_i = 5'b01010; bus.pop_i = 1'b1;
    cycle(); idle();
    check_head("pushpop_occ2", 1'b1, 5'b00010, 2'd1, 3'd2);
    pop_one();
    check_head("pushpop_new_entry", 1'b1, 5'b01010, 2'd1, 3'd1);
    pop_one();
    // Patterns 1..10 in sequence: one in flight, nine push/pop pairs wrap pointers.
    push(5'd1);
    for (int i = 1; i < 10; i++) begin
      bus.rqst_valid_i = 1'b1; bus.rqst_pattern_i = 5'(i + 1); bus.pop_i = 1'b1;
      cycle(); idle();
      check_head("wrap_pair", 1'b1, 5'(i + 1), seqs[i], 3'd1);
    end
    pop_one();
    check_head("wrap_done_empty", 1'b0, 5'b00000, 2'd0, 3'd0);
  endtask

  task automatic test_clr_race_and_reset();
    for (int i = 0; i < 4; i++) push(5'(8 + i));
    bus.rqst_valid_i = 1'b1; bus.rqst_pattern_i = 5'b00111; bus.drc_clr_i = 1'b1;
    cycle(); idle();
    check_status("clr_race_drc3_wins", 1'b0, 3'b100);
    clear_drc();
    check_status("clr_alone", 1'b0, 3'b000);
    pop_one();
    check_head("pre_reset_occ3", 1'b1, 5'b01001, 2'd1, 3'd3);
    #2 rst = 1'b1;
    #1;
    check_head("async_reset_clears", 1'b0, 5'b00000, 2'd0, 3'd0);
    check_status("async_reset_ready", 1'b1, 3'b000);
    cycle();
    rst = 1'b0;
    cycle();
    push(5'b00101);
    check_head("post_reset_push", 1'b1, 5'b00101, 2'd2, 3'd1);
    pop_one();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_push();
    test_seq_drc();
    test_full_drop();
    test_back_to_back();
    test_clr_race_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memshare_arr_rqst_tracker.md
MEMSHARE_ARR_RQST_TRACKER -- requirements
Module: memshare_arr_rqst_tracker

Interface
REQ-001 SHALL have parameter SHARE_GROUP_SIZE, default 5: number of requestors per share group (GP1+GP2).
REQ-002 SHALL have parameter SHARE_COL_CONFIG, default 5'b10101: per-requestor flag, '1' = shared column.
REQ-003 SHALL have parameter TRACK_DEPTH, default 4: tracked pattern slots, power of two, >=2.
REQ-004 SHALL have parameter MAX_ALLOC_SEQ_NUM, default 2: maximum allocation sequences per pattern.
REQ-005 SHALL have parameter DRC_NUM, default 3: number of design-rule-check flags.
REQ-006 SHALL have port sys_clk, input, 1: the single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port rqst_valid_i, input, 1: arrival request pattern valid.
REQ-009 SHALL have port rqst_pattern_i, input, SHARE_GROUP_SIZE: one bit per requestor asserting access.
REQ-010 SHALL have port rqst_ready_o, output, 1: tracker can accept a pattern.
REQ-011 SHALL have port pop_i, input, 1: consumer retires head entry.
REQ-012 SHALL have port entry_valid_o, output, 1: head entry present.
REQ-013 SHALL have port entry_pattern_o, output, SHARE_GROUP_SIZE: head pattern.
REQ-014 SHALL have port entry_seq_num_o, output, $clog2(MAX_ALLOC_SEQ_NUM+1): head allocation-sequence count.
REQ-015 SHALL have port occupancy_o, output, $clog2(TRACK_DEPTH+1): stored entries.
REQ-016 SHALL have port drc_flag_o, output, DRC_NUM: sticky DRC flags indexed by memShare_drc_index.
REQ-017 SHALL have port drc_clr_i, input, 1: clears all DRC flags.

Function
REQ-018 Push SHALL occur when rqst_valid_i && rqst_ready_o; rqst_ready_o SHALL be high iff occupancy_o < TRACK_DEPTH (registered state only, no combinational dependence on pop_i).
REQ-019 Pop SHALL occur when pop_i && entry_valid_o; pop while empty SHALL be ignored without state change.
REQ-020 Simultaneous push and pop SHALL leave occupancy_o unchanged and advance both pointers.
REQ-021 Write/read pointers SHALL wrap modulo TRACK_DEPTH; occupancy SHALL distinguish full from empty.
REQ-022 Head status SHALL follow a three-state FSM EMPTY/PARTIAL/FULL: EMPTY->PARTIAL on push; PARTIAL->FULL on push-only reaching TRACK_DEPTH; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop-only reaching 0; push+pop holds state (in FULL, push blocked since not ready).
REQ-023 A pattern pushed into an empty tracker SHALL appear on entry_* the next cycle (one-cycle latency); entry_* SHALL otherwise update the cycle after a pop.
REQ-024 At push, shared_cnt = popcount(rqst_pattern_i & SHARE_COL_CONFIG); seq_num SHALL be 0 if pattern is all-zero, 1 if nonzero and shared_cnt<=1, else min(shared_cnt, MAX_ALLOC_SEQ_NUM); stored alongside the pattern.
REQ-025 DRC1 SHALL set on a push with shared_cnt > MAX_ALLOC_SEQ_NUM; the entry SHALL still be stored with saturated seq_num.
REQ-026 DRC2 SHALL set on a push of an all-zero pattern; entry stored with seq_num 0.
REQ-027 DRC3 SHALL set when rqst_valid_i is high while full; that pattern SHALL be dropped.
REQ-028 DRC flags SHALL be sticky until drc_clr_i; a set event coincident with drc_clr_i SHALL win.
REQ-029 entry_pattern_o/entry_seq_num_o SHALL be 0 whenever entry_valid_o is low.

Reset
REQ-030 On rst, asynchronously: pointers, occupancy_o, entry_valid_o, entry_pattern_o, entry_seq_num_o, drc_flag_o SHALL be 0; FSM SHALL be EMPTY; rqst_ready_o SHALL be 1 after reset.
REQ-031 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.

Structure
REQ-032 memShare_config_pkg SHALL hold SHARE_GROUP_SIZE, SHARE_COL_CONFIG, ARR_RQST_TRACK_DEPTH, MAX_ALLOC_SEQ_NUM, MEMSHARE_DRC_NUM, memShare_drc_index, and a new tracker FSM state enum and entry struct typedef (pattern, seq_num).
REQ-033 The seq_num/shared_cnt logic SHALL be one combinational sub-module memshare_seq_num_calc.

Verification
REQ-034 Reset, push 5'b00100 -> next cycle entry_valid_o=1, entry_seq_num_o=1, occupancy_o=1, drc_flag_o=3'b000.
REQ-035 Push 5'b10101 -> stored seq_num=2, drc_flag_o[DRC1]=1; push 5'b00000 -> seq_num=0, drc_flag_o[DRC2]=1.
REQ-036 Push 4 patterns without pop -> occupancy_o=4, rqst_ready_o=0; fifth valid -> dropped, drc_flag_o[DRC3]=1, occupancy_o stays 4.
REQ-037 At occupancy 2, push 5'b01010 and pop same cycle -> occupancy_o=2, new entry seq_num=1; wrap pointers through 9 push/pop pairs, FIFO order preserved.
REQ-038 Assert drc_clr_i while DRC3 event occurs -> DRC3 stays 1; next drc_clr_i alone -> drc_flag_o=3'b000; rst with occupancy 3 -> entry_valid_o=0, occupancy_o=0 immediately.
